// File: rtl/shift_left2_unit.sv
// shift_left2_unit: fixed logical left shift for the branch/jump target path.
// Offers a zero-latency combinational result and a one-cycle registered copy
// carrying valid and overflow status.
module shift_left2_unit #(
  parameter int WIDTH = 32,
  parameter int SHAMT = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic             InValid,
  input  logic             Hold,
  output logic [WIDTH-1:0] Out,
  output logic [SHAMT-1:0] Lost,
  output logic [WIDTH-1:0] OutReg,
  output logic [SHAMT-1:0] LostReg,
  output logic             OutValid,
  output logic             Overflow
);

  logic [WIDTH-1:0] shifted;
  logic [SHAMT-1:0] spilled;

  // Combinational shift; the top SHAMT bits fall off and are reported as spilled.
  always_comb begin
    shifted = {In[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
    spilled = In[WIDTH-1 -: SHAMT];
  end

  assign Out  = shifted;
  assign Lost = spilled;

  // Registered stage: reset beats hold; otherwise reload every cycle regardless of InValid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutReg   <= '0;
      LostReg  <= '0;
      OutValid <= 1'b0;
      Overflow <= 1'b0;
    end else if (!Hold) begin
      OutReg   <= shifted;
      LostReg  <= spilled;
      OutValid <= InValid;
      Overflow <= |spilled;
    end
  end

endmodule

// File: tb/tb_shift_left2_unit.sv
// Self-checking bench for shift_left2_unit (WIDTH=32, SHAMT=2).
module tb_shift_left2_unit;

  logic        clk;
  logic        reset;
  logic [31:0] in_d;
  logic        in_valid;
  logic        hold;
  logic [31:0] out_d;
  logic [1:0]  lost;
  logic [31:0] out_reg;
  logic [1:0]  lost_reg;
  logic        out_valid;
  logic        overflow;

  int errors   = 0;
  int n_checks = 0;

  // Reference state for the registered stage
  logic [31:0] m_out_reg;
  logic [1:0]  m_lost_reg;
  logic        m_valid;
  logic        m_ovf;

  shift_left2_unit #(.WIDTH(32), .SHAMT(2)) dut (
    .Clk      (clk),
    .Reset    (reset),
    .In       (in_d),
    .InValid  (in_valid),
    .Hold     (hold),
    .Out      (out_d),
    .Lost     (lost),
    .OutReg   (out_reg),
    .LostReg  (lost_reg),
    .OutValid (out_valid),
    .Overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check the combinational path, clock, check the registered path.
  task automatic cycle(input logic [31:0] a, input logic v, input logic h, input logic r);
    logic [63:0] wide;
    in_d = a; in_valid = v; hold = h; reset = r;
    #1;
    wide = {32'b0, a} << 2;
    check("out", out_d, wide[31:0]);
    check("lost", {30'b0, lost}, wide[63:32]);
    @(posedge clk);
    if (r) begin
      m_out_reg = 0; m_lost_reg = 0; m_valid = 0; m_ovf = 0;
    end else if (!h) begin
      m_out_reg  = wide[31:0];
      m_lost_reg = wide[33:32];
      m_valid    = v;
      m_ovf      = (a / 32'h4000_0000) != 0;
    end
    #1;
    check("out_reg", out_reg, m_out_reg);
    check("lost_reg", {30'b0, lost_reg}, {30'b0, m_lost_reg});
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  initial begin
    in_d = 0; in_valid = 0; hold = 0; reset = 1;
    m_out_reg = 0; m_lost_reg = 0; m_valid = 0; m_ovf = 0;

    // reset state
    cycle(32'h0000_0000, 1'b0, 1'b0, 1'b1);
    cycle(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);

    // directed vectors
    cycle(32'h0000_0001, 1'b1, 1'b0, 1'b0);
    check("dir_one_out_reg", out_reg, 32'h0000_0004);
    cycle(32'h0000_0001, 1'b0, 1'b0, 1'b0);
    check("dir_valid_follows", {31'b0, out_valid}, 32'h0);
    cycle(32'hC000_0003, 1'b1, 1'b0, 1'b0);
    check("dir_c3_out_reg", out_reg, 32'h0000_000C);
    check("dir_c3_ovf", {31'b0, overflow}, 32'h1);
    cycle(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    check("dir_ones_out", out_d, 32'hFFFF_FFFC);
    check("dir_ones_lost", {30'b0, lost_reg}, 32'h3);
    cycle(32'h3FFF_FFFF, 1'b1, 1'b0, 1'b0);
    check("dir_3f_out_reg", out_reg, 32'hFFFF_FFFC);
    check("dir_3f_ovf", {31'b0, overflow}, 32'h0);
    cycle(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    check("dir_zero_out_reg", out_reg, 32'h0);

    // hold freezes the registered stage
    cycle(32'h0000_0010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(32'h0000_0001, 1'b0, 1'b1, 1'b0);
      check("hold_keep", out_reg, 32'h0000_0040);
      check("hold_keep_valid", {31'b0, out_valid}, 32'h1);
    end
    cycle(32'h0000_0001, 1'b1, 1'b0, 1'b0);
    check("hold_release", out_reg, 32'h0000_0004);

    // reset beats hold
    cycle(32'hC000_0003, 1'b1, 1'b0, 1'b0);
    cycle(32'h0000_0005, 1'b1, 1'b1, 1'b1);
    check("rst_hold_out_reg", out_reg, 32'h0);
    check("rst_hold_valid", {31'b0, out_valid}, 32'h0);
    check("rst_hold_ovf", {31'b0, overflow}, 32'h0);
    check("rst_hold_comb", out_d, 32'h0000_0014);

    // randomized traffic with occasional stalls and resets
    for (int i = 0; i < 1000; i++) begin
      cycle($urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
